// File: rtl/sys_bus_arbiter.sv
// Round-robin arbiter sharing the CPU bus between two DMA masters through the
// BREQ_B / BA / BS handshake, with burst limiting and a sticky grant-timeout flag.
module sys_bus_arbiter #(
    parameter int BURST_MAX = 14,
    parameter int GRANT_TMO = 63
) (
    input  logic       ECLK,
    input  logic       RESET_B,
    input  logic [1:0] REQ,
    input  logic       BA,
    input  logic       BS,
    output logic       BREQ_B,
    output logic [1:0] GNT,
    output logic       TMO_ERR
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQUEST = 2'd1,
        GRANT   = 2'd2,
        RELEASE = 2'd3
    } state_t;

    localparam logic [3:0] BURST_LAST = 4'(BURST_MAX - 1);
    localparam logic [7:0] TMO_LAST   = 8'(GRANT_TMO - 1);

    state_t     state, next_state;
    logic       winner, next_winner;
    logic       last_gnt, next_last_gnt;
    logic [3:0] burst_cnt, next_burst_cnt;
    logic [7:0] tmo_cnt, next_tmo_cnt;
    logic       next_breq_b;
    logic [1:0] next_gnt;
    logic       next_tmo_err;

    logic bus_granted;
    logic winner_req;

    assign bus_granted = BA & BS;
    assign winner_req  = REQ[winner];

    always_ff @(posedge ECLK or negedge RESET_B) begin
        if (!RESET_B) begin
            state     <= IDLE;
            winner    <= 1'b0;
            last_gnt  <= 1'b1;
            burst_cnt <= '0;
            tmo_cnt   <= '0;
            BREQ_B    <= 1'b1;
            GNT       <= 2'b00;
            TMO_ERR   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make every register sample the
            // pre-edge values, independent of statement order.
            state     <= next_state;
            winner    <= next_winner;
            last_gnt  <= next_last_gnt;
            burst_cnt <= next_burst_cnt;
            tmo_cnt   <= next_tmo_cnt;
            BREQ_B    <= next_breq_b;
            GNT       <= next_gnt;
            TMO_ERR   <= next_tmo_err;
        end
    end

    always_comb begin
        // NOTE: every variable gets a default before the case, so no path
        // leaves one unassigned and no latch is inferred.
        next_state     = state;
        next_winner    = winner;
        next_last_gnt  = last_gnt;
        next_burst_cnt = burst_cnt;
        next_tmo_cnt   = tmo_cnt;
        next_tmo_err   = TMO_ERR;

        case (state)
            IDLE: begin
                if (|REQ) begin
                    next_state   = REQUEST;
                    next_winner  = (REQ == 2'b11) ? ~last_gnt : REQ[1];
                    next_tmo_cnt = '0;
                end
            end
            REQUEST: begin
                // A withdrawn request beats a same-cycle grant: never pulse GNT
                // at a master that no longer wants the bus.
                if (!winner_req) begin
                    next_state = RELEASE;
                end else if (bus_granted) begin
                    next_state     = GRANT;
                    next_burst_cnt = '0;
                    next_last_gnt  = winner;
                end else if (tmo_cnt == TMO_LAST) begin
                    next_state   = RELEASE;
                    next_tmo_err = 1'b1;
                end else begin
                    next_tmo_cnt = tmo_cnt + 8'd1;
                end
            end
            GRANT: begin
                next_burst_cnt = burst_cnt + 4'd1;
                if (!bus_granted || !winner_req || burst_cnt == BURST_LAST) begin
                    next_state = RELEASE;
                end
            end
            RELEASE: begin
                if (!bus_granted) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase

        // Outputs are registered images of the next state, so no input can
        // reach an output combinationally and GNT implies BREQ_B low.
        next_breq_b = !(next_state == REQUEST || next_state == GRANT);
        next_gnt    = 2'b00;
        if (next_state == GRANT) begin
            next_gnt = next_winner ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: tb/tb_sys_bus_arbiter.sv
// Scoreboard bench for sys_bus_arbiter: whole-burst transactions are predicted by
// a transaction-level model and compared against what a passive monitor observes.
module tb_sys_bus_arbiter;

    localparam int BURST_MAX = 14;
    localparam int GRANT_TMO = 63;

    typedef enum int {M_FULL, M_DROP, M_BUSLOSS, M_ABORT, M_TMO} mode_e;

    typedef struct {
        logic       abort;
        logic [1:0] gnt;
        int         lat;
        int         len;
        int         gap;
        logic       tmo;
    } exp_t;

    logic       ECLK = 1'b0;
    logic       RESET_B;
    logic [1:0] REQ;
    logic       BA;
    logic       BS;
    logic       BREQ_B;
    logic [1:0] GNT;
    logic       TMO_ERR;

    int   tests = 0;
    int   fails = 0;
    exp_t sb[$];
    logic mon_en    = 1'b0;
    logic m_last    = 1'b1;
    logic m_tmo     = 1'b0;
    logic first_txn = 1'b1;

    sys_bus_arbiter #(
        .BURST_MAX(BURST_MAX),
        .GRANT_TMO(GRANT_TMO)
    ) dut (
        .ECLK   (ECLK),
        .RESET_B(RESET_B),
        .REQ    (REQ),
        .BA     (BA),
        .BS     (BS),
        .BREQ_B (BREQ_B),
        .GNT    (GNT),
        .TMO_ERR(TMO_ERR)
    );

    always #5 ECLK = ~ECLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: samples on the falling edge and reconstructs each request episode.
    initial begin : monitor
        logic       prev_breq_b;
        logic [1:0] prev_gnt;
        logic [1:0] gnt_seen;
        logic       granted;
        int         low_cnt;
        int         high_cnt;
        int         lat;
        int         glen;
        exp_t       e;
        prev_breq_b = 1'b1;
        prev_gnt    = 2'b00;
        gnt_seen    = 2'b00;
        granted     = 1'b0;
        low_cnt     = 0;
        high_cnt    = 0;
        lat         = 0;
        glen        = 0;
        forever begin
            @(negedge ECLK);
            if (mon_en) begin
                low_cnt++;
                high_cnt++;
                glen++;
                check("gnt_legal", {31'b0, (GNT != 2'b11) && !(GNT != 2'b00 && BREQ_B)}, 1);
                if (prev_breq_b && !BREQ_B) begin
                    if (sb.size() == 0) check("sb_unexpected_request", 1, 0);
                    else if (sb[0].gap != 0) check("release_gap", high_cnt, sb[0].gap);
                    low_cnt = 0;
                    granted = 1'b0;
                end
                if (!prev_breq_b && BREQ_B) high_cnt = 0;
                if (prev_gnt == 2'b00 && GNT != 2'b00) begin
                    granted  = 1'b1;
                    gnt_seen = GNT;
                    lat      = low_cnt;
                    glen     = 0;
                end
                if (prev_gnt != 2'b00 && GNT == 2'b00) begin
                    if (sb.size() == 0) check("sb_underflow_burst", 1, 0);
                    else begin
                        e = sb.pop_front();
                        check("burst_expected", e.abort, 0);
                        check("burst_winner", gnt_seen, e.gnt);
                        check("grant_latency", lat, e.lat);
                        check("burst_length", glen, e.len);
                        check("breq_b_at_gnt_drop", BREQ_B, 1);
                        check("tmo_err_after_burst", TMO_ERR, e.tmo);
                    end
                end
                if (!prev_breq_b && BREQ_B && !granted) begin
                    if (sb.size() == 0) check("sb_underflow_abort", 1, 0);
                    else begin
                        e = sb.pop_front();
                        check("abort_expected", e.abort, 1);
                        check("request_length", low_cnt, e.len);
                        check("tmo_err_after_abort", TMO_ERR, e.tmo);
                    end
                end
            end
            prev_breq_b = BREQ_B;
            prev_gnt    = GNT;
        end
    end

    task automatic wait_breq(input logic level, input int limit, input string name);
        int n = 0;
        while (BREQ_B !== level && n < limit) begin
            @(negedge ECLK);
            n++;
        end
        if (BREQ_B !== level) check(name, BREQ_B, level);
    endtask

    task automatic wait_gnt(input int limit, input string name);
        int n = 0;
        while (GNT === 2'b00 && n < limit) begin
            @(negedge ECLK);
            n++;
        end
        if (GNT === 2'b00) check(name, GNT, 2'b11);
    endtask

    // One request episode. Called on a falling edge while BREQ_B is high.
    // d: cycles before the bus answers (or the request is withdrawn),
    // k: grant cycle in which REQ drops or the bus is lost, h: extra cycles the
    // bus stays granted at the start, holding the block in RELEASE.
    task automatic run_txn(input logic [1:0] p, input mode_e mode, input int d,
                           input int k, input int h);
        exp_t e;
        logic w;
        int   j;
        w       = (p == 2'b11) ? ~m_last : p[1];
        e.abort = (mode == M_ABORT || mode == M_TMO);
        e.gnt   = w ? 2'b10 : 2'b01;
        e.lat   = d + 1;
        e.gap   = first_txn ? 0 : h + 2;
        case (mode)
            M_TMO:   e.len = GRANT_TMO;
            M_ABORT: e.len = d + 1;
            default: e.len = (k < BURST_MAX) ? k : BURST_MAX;
        endcase
        if (mode == M_TMO) m_tmo = 1'b1;
        if (!e.abort) m_last = w;
        e.tmo     = m_tmo;
        first_txn = 1'b0;
        sb.push_back(e);

        REQ = p;
        BA  = (h > 0);
        BS  = (h > 0);
        repeat (h) @(negedge ECLK);
        BA = 1'b0;
        BS = 1'b0;
        wait_breq(1'b0, 20, "wait_request");
        case (mode)
            M_TMO: wait_breq(1'b1, GRANT_TMO + 10, "wait_timeout");
            M_ABORT: begin
                repeat (d) @(negedge ECLK);
                REQ[w] = 1'b0;
                wait_breq(1'b1, 10, "wait_abort");
            end
            default: begin
                repeat (d) @(negedge ECLK);
                BA = 1'b1;
                BS = 1'b1;
                wait_gnt(20, "wait_grant");
                j = 0;
                while (GNT != 2'b00 && j < BURST_MAX + 4) begin
                    if (j == k - 1) begin
                        if (mode == M_DROP) REQ[w] = 1'b0;
                        else if (mode == M_BUSLOSS) begin
                            case ($urandom_range(0, 2))
                                0:       BA = 1'b0;
                                1:       BS = 1'b0;
                                default: begin BA = 1'b0; BS = 1'b0; end
                            endcase
                        end
                    end
                    @(negedge ECLK);
                    j++;
                end
                if (GNT != 2'b00) check("wait_burst_end", GNT, 2'b00);
            end
        endcase
    endtask

    initial begin : stimulus
        RESET_B = 1'b0;
        REQ     = 2'b00;
        BA      = 1'b0;
        BS      = 1'b0;
        #12;
        check("reset_breq_b", BREQ_B, 1);
        check("reset_gnt", GNT, 2'b00);
        check("reset_tmo_err", TMO_ERR, 0);
        @(negedge ECLK);
        RESET_B = 1'b1;
        mon_en  = 1'b1;

        // Continuous 11 rotates 01,10,01; then single request, bus loss,
        // timeout, early drop in cycle 5, withdrawal before grant.
        run_txn(2'b11, M_FULL, 0, 99, 0);
        run_txn(2'b11, M_FULL, 0, 99, 0);
        run_txn(2'b11, M_FULL, 0, 99, 0);
        run_txn(2'b01, M_FULL, 1, 99, 2);
        run_txn(2'b11, M_BUSLOSS, 0, 4, 0);
        run_txn(2'b10, M_TMO, 0, 0, 1);
        run_txn(2'b01, M_DROP, 2, 5, 0);
        run_txn(2'b10, M_ABORT, 2, 0, 0);

        for (int t = 0; t < 40; t++) begin
            logic [1:0] p;
            int         r;
            mode_e      m;
            p = 2'($urandom_range(1, 3));
            r = int'($urandom_range(0, 9));
            m = (r < 3) ? M_FULL : (r < 6) ? M_DROP : (r < 8) ? M_BUSLOSS :
                (r == 8) ? M_ABORT : M_TMO;
            run_txn(p, m, int'($urandom_range(0, 4)),
                    (m == M_FULL) ? 99 : int'($urandom_range(1, 16)),
                    int'($urandom_range(0, 3)));
        end

        REQ = 2'b00;
        BA  = 1'b0;
        BS  = 1'b0;
        repeat (4) @(negedge ECLK);
        check("sb_drained", sb.size(), 0);
        mon_en = 1'b0;

        // Asynchronous reset in the middle of a grant to master 0.
        REQ = 2'b01;
        wait_breq(1'b0, 20, "wait_pre_reset_request");
        BA = 1'b1;
        BS = 1'b1;
        wait_gnt(20, "wait_pre_reset_grant");
        repeat (3) @(negedge ECLK);
        check("gnt_before_reset", GNT, 2'b01);
        #2 RESET_B = 1'b0;
        #1;
        check("rst_async_gnt", GNT, 2'b00);
        check("rst_async_breq_b", BREQ_B, 1);
        check("rst_async_tmo_err", TMO_ERR, 0);
        @(negedge ECLK);
        @(negedge ECLK);
        check("rst_held_gnt", GNT, 2'b00);
        REQ     = 2'b11;
        BA      = 1'b0;
        BS      = 1'b0;
        RESET_B = 1'b1;
        wait_breq(1'b0, 20, "wait_post_reset_request");
        BA = 1'b1;
        BS = 1'b1;
        wait_gnt(20, "wait_post_reset_grant");
        check("rr_after_reset", GNT, 2'b01);
        check("tmo_err_after_reset", TMO_ERR, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, got %0d failures so far, expected completion", fails);
        $fatal(1, "watchdog expired");
    end

endmodule
